// File: rtl/com_cs_arq.sv
// com_cs_arq: stop-and-wait command/reply sequencer between the local
// controller and the com link layer. A command is sent, a reply whose
// btype alternates BT_RX0/BT_RX1 is awaited, and the command is retried on
// timeout or on an out-of-sequence reply, up to MAX_RETRY times, before err
// is flagged. Unsolicited link frames are forwarded to the controller.
// Optional feature macro: COM_CS_STAT_EN adds the stat_retry counter port.
module com_cs_arq #(
  parameter int unsigned         BTYPE_W   = 4,
  parameter logic [BTYPE_W-1:0]  BT_INIT   = 4'h0,
  parameter logic [BTYPE_W-1:0]  BT_RX0    = 4'h2,
  parameter logic [BTYPE_W-1:0]  BT_RX1    = 4'hD,
  parameter int unsigned         LATENCY   = 4,
  parameter int unsigned         CNT_W     = 12,
  parameter int unsigned         TIMEOUT   = 1024,
  parameter int unsigned         MAX_RETRY = 3,
  parameter int unsigned         RETRY_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fs_send,
  output logic               fd_send,
  output logic               err,
  output logic               fs_read,
  input  logic               fd_read,
  output logic               fs_com_send,
  input  logic               fd_com_send,
  input  logic               fs_com_read,
  output logic               fd_com_read,
  input  logic [BTYPE_W-1:0] btype,
  input  logic               seq_clr
`ifdef COM_CS_STAT_EN
  ,
  output logic [15:0]        stat_retry
`endif
);

  typedef enum logic [3:0] {
    MAIN_IDLE,
    MAIN_WAIT,
    SEND_WORK,
    SEND_WAIT,
    WAIT_IDLE,
    WAIT_READ,
    WAIT_TAKE,
    RETRY,
    SEND_DONE,
    SEND_FAIL,
    READ_WAIT,
    READ_DONE
  } state_t;

  // Entry point of every (re)send: SEND_WORK is skipped entirely when there
  // is no pre-send latency to burn.
  localparam state_t SEND_FIRST = (LATENCY == 0) ? SEND_WAIT : SEND_WORK;

  localparam logic [CNT_W-1:0]   LAT_LAST  = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [RETRY_W-1:0] retry, retry_d;
  logic [BTYPE_W-1:0] last_bt, last_bt_d;
  logic [BTYPE_W-1:0] reply_bt, reply_bt_d;
  logic               reply_is_rx;
  logic               reply_in_seq;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MAIN_IDLE;
      cnt      <= '0;
      retry    <= '0;
      last_bt  <= BT_INIT;
      reply_bt <= BT_INIT;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      retry    <= retry_d;
      last_bt  <= last_bt_d;
      reply_bt <= reply_bt_d;
    end
  end

  // Reply acceptance: the reply must be one of the two alternating types and
  // must either start a fresh sequence or be the opposite of the last one.
  always_comb begin
    reply_is_rx  = (reply_bt == BT_RX0) || (reply_bt == BT_RX1);
    reply_in_seq = (last_bt == BT_INIT)
                || ({last_bt, reply_bt} == {BT_RX0, BT_RX1})
                || ({last_bt, reply_bt} == {BT_RX1, BT_RX0});
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    retry_d    = retry;
    last_bt_d  = last_bt;
    reply_bt_d = reply_bt;
    case (state)
      MAIN_IDLE: state_d = MAIN_WAIT;
      MAIN_WAIT: begin
        if (seq_clr) last_bt_d = BT_INIT;
        if (fs_com_read) begin
          state_d = READ_WAIT;
        end else if (fs_send) begin
          state_d = SEND_FIRST;
          retry_d = '0;
        end
      end
      SEND_WORK: begin
        if (cnt == LAT_LAST) begin
          state_d = SEND_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SEND_WAIT: begin
        if (fd_com_send) begin
          state_d = WAIT_IDLE;
          cnt_d   = '0;
        end
      end
      WAIT_IDLE: begin
        if (fs_com_read) begin
          // btype is already valid here; capturing it now keeps reply_bt
          // correct even for a frame that is dropped after one cycle.
          state_d    = WAIT_READ;
          cnt_d      = '0;
          reply_bt_d = btype;
        end else if (cnt == TO_LAST) begin
          state_d = RETRY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT_READ: begin
        if (fs_com_read) reply_bt_d = btype;
        else             state_d    = WAIT_TAKE;
      end
      WAIT_TAKE: begin
        if (reply_is_rx && reply_in_seq) begin
          state_d   = SEND_DONE;
          last_bt_d = reply_bt;
        end else begin
          state_d = RETRY;
        end
      end
      RETRY: begin
        if (retry == RETRY_MAX) begin
          state_d = SEND_FAIL;
        end else begin
          retry_d = retry + 1'b1;
          state_d = SEND_FIRST;
        end
      end
      SEND_DONE, SEND_FAIL: begin
        if (!fs_send) state_d = MAIN_WAIT;
      end
      READ_WAIT: begin
        if (fd_read) state_d = READ_DONE;
      end
      READ_DONE: begin
        if (!fs_com_read) state_d = MAIN_WAIT;
      end
      default: state_d = MAIN_IDLE;
    endcase
  end

  // Outputs are decodes of the registered state only.
  always_comb begin
    fs_com_send = (state == SEND_WAIT);
    fd_send     = (state == SEND_DONE) || (state == SEND_FAIL);
    err         = (state == SEND_FAIL);
    fs_read     = (state == READ_WAIT);
    fd_com_read = (state == READ_DONE);
  end

`ifdef COM_CS_STAT_EN
  // Saturating count of every retry that leads to a resend.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_retry <= '0;
    end else if ((state == RETRY) && (retry != RETRY_MAX) && (stat_retry != '1)) begin
      stat_retry <= stat_retry + 16'd1;
    end
  end
`endif

endmodule
